count_wrap_monitor: RTL and testbench
=====================================

COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 Parameter BITS, default 4, width of the monitored count bus.
REQ-002 Parameter SAT_W, default 8, width of the wrap event counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 count  input  BITS  value from the upstream up/down counter, sampled each posedge clk.
REQ-006 sel  input  1  upstream direction: 1 = up, 0 = down.
REQ-007 evt_ack  input  1  consumer acknowledges the pending wrap event.
REQ-008 wrap_up  output  1  one-cycle pulse on up-wrap (MAX to 0).
REQ-009 wrap_down  output  1  one-cycle pulse on down-wrap (0 to MAX).
REQ-010 dir_change  output  1  one-cycle pulse when sel differs from its previously sampled value.
REQ-011 evt_valid  output  1  a wrap event is pending; held until acknowledged.
REQ-012 evt_dir  output  1  direction of the pending event: 1 = up-wrap, 0 = down-wrap.
REQ-013 wrap_cnt  output  SAT_W  saturating total of detected wraps, both directions.
REQ-014 evt_ovf  output  1  sticky flag: a wrap was detected while an event was already pending.

Function
REQ-015 MAX SHALL equal 2^BITS-1; the block SHALL keep registers prev_q (BITS), sel_q (1) and prev_vld (1).
REQ-016 Each posedge SHALL load prev_q <= count and sel_q <= sel, and set prev_vld to 1.
REQ-017 Up-wrap is detected when prev_vld=1, prev_q=MAX and count=0; down-wrap when prev_vld=1, prev_q=0 and count=MAX.
REQ-018 wrap_up/wrap_down SHALL be registered and high for exactly one cycle, following the edge at which the wrap is detected (1-cycle latency).
REQ-019 Any other prev_q/count pair, including a hold or a jump, SHALL NOT produce a wrap pulse.
REQ-020 dir_change SHALL pulse one cycle after an edge at which prev_vld=1 and sel differs from sel_q.
REQ-021 Event FSM has two states, IDLE and PEND; evt_valid=1 exactly in PEND.
REQ-022 IDLE with a wrap detected: go to PEND; latch evt_dir.
REQ-023 PEND with evt_ack=1 and no wrap detected: go to IDLE.
REQ-024 PEND with evt_ack=1 and a wrap detected in the same cycle: stay in PEND; evt_dir takes the new direction; no overflow.
REQ-025 PEND with evt_ack=0 and a wrap detected: stay in PEND; evt_dir unchanged (first event kept); overflow condition raised (see REQ-030).
REQ-026 evt_ack in IDLE SHALL be ignored.
REQ-027 wrap_cnt SHALL increment by 1 on each detected wrap and saturate at 2^SAT_W-1; it never wraps.

Reset
REQ-028 While reset=0, all of the following SHALL hold asynchronously: FSM=IDLE, prev_vld=0, prev_q=MAX, sel_q=1, wrap_cnt=0, and wrap_up, wrap_down, dir_change, evt_valid, evt_dir and evt_ovf all 0.
REQ-029 The first posedge after reset release SHALL NOT produce a wrap or dir_change pulse; reset asserted in PEND SHALL drop the pending event.

Configuration
REQ-030 With macro WRAP_MON_OVF_EN defined: evt_ovf SHALL be set by REQ-025, stay set, and clear only on the cycle after an accepted evt_ack (PEND with evt_ack=1).
REQ-031 Without WRAP_MON_OVF_EN: evt_ovf SHALL be tied to 0; REQ-025 drops the event silently; wrap_cnt still counts it.

Verification
REQ-032 BITS=4. Release reset, sel=1, count 13,14,15,0,1 -> wrap_up high exactly 1 cycle after the 15->0 sample; evt_valid=1, evt_dir=1, wrap_cnt=1.
REQ-033 sel=0, count 2,1,0,15 -> wrap_down pulses once, evt_dir=0; evt_ack=1 for one cycle -> evt_valid=0 on the next cycle.
REQ-034 Release reset with count=15 held, then count=0 -> wrap_up pulses; count held at 0 with sel toggled 1->0 -> dir_change pulses once, no wrap pulse.
REQ-035 Pending up-event, no ack, then a down-wrap -> evt_dir stays 1, wrap_cnt=2, evt_ovf=1 (with macro) or 0 (without); ack -> evt_ovf cleared.
REQ-036 Pending event, evt_ack=1 on the same cycle as a new down-wrap -> evt_valid stays 1, evt_dir=0, evt_ovf=0.
REQ-037 SAT_W=2, five wraps -> wrap_cnt=3; reset=0 mid-PEND -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor
//   Watches the value of an upstream up/down counter and reports when it
//   wraps, either MAX->0 (up-wrap) or 0->MAX (down-wrap). A wrap is reported
//   in three ways:
//   - a one-cycle pulse on wrap_up or wrap_down
//   - a pending event (evt_valid/evt_dir) that is held until evt_ack
//   - a saturating count of all wraps (wrap_cnt)
//   It also pulses dir_change whenever the upstream direction input flips.
//
// Parameters
//   BITS   width of the monitored count bus (MAX = 2^BITS-1)
//   SAT_W  width of the saturating wrap counter
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   reset       asynchronous, active-low reset (0 = in reset)
//   count       upstream counter value, sampled every rising edge
//   sel         upstream direction, 1 = up, 0 = down
//   evt_ack     consumer accepts the pending wrap event
//   wrap_up     one-cycle pulse after an up-wrap (MAX->0) is seen
//   wrap_down   one-cycle pulse after a down-wrap (0->MAX) is seen
//   dir_change  one-cycle pulse after sel differs from its last sample
//   evt_valid   a wrap event is pending
//   evt_dir     direction of the pending event, 1 = up-wrap, 0 = down-wrap
//   wrap_cnt    saturating number of wraps seen, both directions
//   evt_ovf     sticky flag: a wrap arrived while an event was still pending
//
// Configuration
//   WRAP_MON_OVF_EN  when defined, evt_ovf is implemented. When undefined,
//                    evt_ovf is tied to 0 and a wrap that arrives while an
//                    unacknowledged event is pending is dropped silently.
//                    wrap_cnt still counts that wrap in both builds.

module count_wrap_monitor #(
  parameter int BITS  = 4,
  parameter int SAT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BITS-1:0]  count,
  input  logic             sel,
  input  logic             evt_ack,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic             dir_change,
  output logic             evt_valid,
  output logic             evt_dir,
  output logic [SAT_W-1:0] wrap_cnt,
  output logic             evt_ovf
);

  localparam logic [BITS-1:0]  MAX     = {BITS{1'b1}};
  localparam logic [SAT_W-1:0] CNT_MAX = {SAT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            dir_next;

  logic [BITS-1:0] prev_q;
  logic            sel_q;
  logic            prev_vld;

  logic            up_det;
  logic            down_det;
  logic            wrap_det;

  // Wrap detection compares the previous sample with the current one. The
  // prev_vld guard stops the reset value of prev_q (MAX) from producing a
  // false up-wrap on the first edge after reset when count is 0.
  always_comb begin
    up_det   = prev_vld && (prev_q == MAX) && (count == '0);
    down_det = prev_vld && (prev_q == '0) && (count == MAX);
    wrap_det = up_det || down_det;
  end

  // The previous count and direction are sampled every cycle. prev_q resets
  // to MAX and sel_q to 1 (up), which matches the state of an up-counter
  // that is about to start from 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q   <= MAX;
      sel_q    <= 1'b1;
      prev_vld <= 1'b0;
    end else begin
      prev_q   <= count;
      sel_q    <= sel;
      prev_vld <= 1'b1;
    end
  end

  // The pulse outputs are registered, so each one is high for exactly the
  // cycle that follows the edge where its condition was seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_up    <= 1'b0;
      wrap_down  <= 1'b0;
      dir_change <= 1'b0;
    end else begin
      wrap_up    <= up_det;
      wrap_down  <= down_det;
      dir_change <= prev_vld && (sel != sel_q);
    end
  end

  // The event state register and the latched direction. A reset drops any
  // pending event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      evt_dir <= 1'b0;
    end else begin
      state   <= state_next;
      evt_dir <= dir_next;
    end
  end

  // Event next-state logic. If an acknowledge and a new wrap arrive in the
  // same cycle, the old event is consumed and the new one takes its place.
  // A wrap with no acknowledge keeps the first event and its direction.
  always_comb begin
    state_next = state;
    dir_next   = evt_dir;
    unique case (state)
      IDLE: begin
        if (wrap_det) begin
          state_next = PEND;
          dir_next   = up_det;
        end
      end
      PEND: begin
        if (evt_ack) begin
          if (wrap_det) begin
            dir_next = up_det;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign evt_valid = (state == PEND);

  // The wrap counter saturates at all-ones rather than rolling over, so a
  // large value always means "at least this many" wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_cnt <= '0;
    end else if (wrap_det && (wrap_cnt != CNT_MAX)) begin
      wrap_cnt <= wrap_cnt + 1'b1;
    end
  end

`ifdef WRAP_MON_OVF_EN
  logic ovf_set;
  logic ack_taken;

  // An accepted acknowledge clears the flag, and this takes priority. In
  // that case any wrap seen in the same cycle replaces the pending event,
  // so it is not an overflow.
  always_comb begin
    ack_taken = (state == PEND) && evt_ack;
    ovf_set   = (state == PEND) && !evt_ack && wrap_det;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_ovf <= 1'b0;
    end else if (ack_taken) begin
      evt_ovf <= 1'b0;
    end else if (ovf_set) begin
      evt_ovf <= 1'b1;
    end
  end
`else
  assign evt_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_count_wrap_monitor.sv
// tb_count_wrap_monitor
//   Directed test of count_wrap_monitor with BITS=4. Two instances share the
//   same inputs. The main instance uses SAT_W=8. The second uses SAT_W=2 so
//   the saturation of wrap_cnt at 3 can be seen within a short sequence.
//   Inputs are driven 1 time unit after a rising edge, and outputs are
//   sampled 1 time unit after the next rising edge.

module tb_count_wrap_monitor;

  localparam int BITS = 4;

`ifdef WRAP_MON_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic [BITS-1:0] count;
  logic            sel;
  logic            evt_ack;

  logic            wrap_up;
  logic            wrap_down;
  logic            dir_change;
  logic            evt_valid;
  logic            evt_dir;
  logic [7:0]      wrap_cnt;
  logic            evt_ovf;

  logic            wrap_up2;
  logic            wrap_down2;
  logic            dir_change2;
  logic            evt_valid2;
  logic            evt_dir2;
  logic [1:0]      wrap_cnt2;
  logic            evt_ovf2;

  int checks;
  int failures;

  count_wrap_monitor #(.BITS(BITS), .SAT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .sel        (sel),
    .evt_ack    (evt_ack),
    .wrap_up    (wrap_up),
    .wrap_down  (wrap_down),
    .dir_change (dir_change),
    .evt_valid  (evt_valid),
    .evt_dir    (evt_dir),
    .wrap_cnt   (wrap_cnt),
    .evt_ovf    (evt_ovf)
  );

  count_wrap_monitor #(.BITS(BITS), .SAT_W(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .sel        (sel),
    .evt_ack    (evt_ack),
    .wrap_up    (wrap_up2),
    .wrap_down  (wrap_down2),
    .dir_change (dir_change2),
    .evt_valid  (evt_valid2),
    .evt_dir    (evt_dir2),
    .wrap_cnt   (wrap_cnt2),
    .evt_ovf    (evt_ovf2)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a broken build cannot hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // All comparisons go through this task.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one vector and let one rising edge consume it. Outputs are
  // sampled #1 after that edge.
  task automatic applyStimulus(input logic [BITS-1:0] c, input logic s,
                               input logic a);
    count   = c;
    sel     = s;
    evt_ack = a;
    @(posedge clk);
    #1;
  endtask

  // Check every output of the main instance against reset values.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".wrap_up"},    32'(wrap_up),    0);
    checkOutput({tag, ".wrap_down"},  32'(wrap_down),  0);
    checkOutput({tag, ".dir_change"}, 32'(dir_change), 0);
    checkOutput({tag, ".evt_valid"},  32'(evt_valid),  0);
    checkOutput({tag, ".evt_dir"},    32'(evt_dir),    0);
    checkOutput({tag, ".wrap_cnt"},   32'(wrap_cnt),   0);
    checkOutput({tag, ".evt_ovf"},    32'(evt_ovf),    0);
    checkOutput({tag, ".wrap_cnt2"},  32'(wrap_cnt2),  0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    count    = '0;
    sel      = 1'b1;
    evt_ack  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");

    // First edge after release: count=0 with reset prev_q=MAX, and sel=0
    // against reset sel_q=1. Neither may pulse.
    reset = 1'b1;
    applyStimulus(4'd0, 1'b0, 1'b0);
    checkOutput("first_edge.wrap_up",    32'(wrap_up),    0);
    checkOutput("first_edge.dir_change", 32'(dir_change), 0);

    // Up sequence 13,14,15,0,1. The first vector flips sel back to 1.
    applyStimulus(4'd13, 1'b1, 1'b0);
    checkOutput("up.dir_change", 32'(dir_change), 1);
    applyStimulus(4'd14, 1'b1, 1'b0);
    checkOutput("up.dir_change_drop", 32'(dir_change), 0);
    applyStimulus(4'd15, 1'b1, 1'b0);
    checkOutput("up.pre_wrap", 32'(wrap_up), 0);
    applyStimulus(4'd0, 1'b1, 1'b0);
    checkOutput("up.wrap_up",   32'(wrap_up),   1);
    checkOutput("up.wrap_down", 32'(wrap_down), 0);
    checkOutput("up.evt_valid", 32'(evt_valid), 1);
    checkOutput("up.evt_dir",   32'(evt_dir),   1);
    checkOutput("up.wrap_cnt",  32'(wrap_cnt),  1);
    applyStimulus(4'd1, 1'b1, 1'b0);
    checkOutput("up.pulse_len", 32'(wrap_up),   0);
    checkOutput("up.held",      32'(evt_valid), 1);
    applyStimulus(4'd1, 1'b1, 1'b1);
    checkOutput("up.ack", 32'(evt_valid), 0);

    // Down sequence 2,1,0,15.
    applyStimulus(4'd2, 1'b0, 1'b0);
    checkOutput("down.dir_change", 32'(dir_change), 1);
    applyStimulus(4'd1, 1'b0, 1'b0);
    applyStimulus(4'd0, 1'b0, 1'b0);
    checkOutput("down.pre_wrap", 32'(wrap_down), 0);
    applyStimulus(4'd15, 1'b0, 1'b0);
    checkOutput("down.wrap_down", 32'(wrap_down), 1);
    checkOutput("down.wrap_up",   32'(wrap_up),   0);
    checkOutput("down.evt_dir",   32'(evt_dir),   0);
    checkOutput("down.evt_valid", 32'(evt_valid), 1);
    checkOutput("down.wrap_cnt",  32'(wrap_cnt),  2);
    checkOutput("down.wrap_cnt2", 32'(wrap_cnt2), 2);
    applyStimulus(4'd15, 1'b0, 1'b1);
    checkOutput("down.pulse_len", 32'(wrap_down), 0);
    checkOutput("down.ack",       32'(evt_valid), 0);

    // A held value and jumps must not produce a wrap pulse.
    applyStimulus(4'd15, 1'b0, 1'b0);
    checkOutput("hold.wrap_down", 32'(wrap_down), 0);
    applyStimulus(4'd7, 1'b0, 1'b0);
    applyStimulus(4'd3, 1'b0, 1'b0);
    checkOutput("jump.wrap_up",   32'(wrap_up),   0);
    checkOutput("jump.wrap_down", 32'(wrap_down), 0);
    checkOutput("jump.wrap_cnt",  32'(wrap_cnt),  2);

    // Overflow: an up-event is pending, then a down-wrap arrives with no
    // acknowledge.
    applyStimulus(4'd15, 1'b0, 1'b0);
    applyStimulus(4'd0, 1'b0, 1'b0);
    checkOutput("ovf.first_dir", 32'(evt_dir),   1);
    checkOutput("ovf.wrap_cnt2", 32'(wrap_cnt2), 3);
    applyStimulus(4'd15, 1'b0, 1'b0);
    checkOutput("ovf.wrap_down", 32'(wrap_down), 1);
    checkOutput("ovf.evt_dir",   32'(evt_dir),   1);
    checkOutput("ovf.evt_valid", 32'(evt_valid), 1);
    checkOutput("ovf.wrap_cnt",  32'(wrap_cnt),  4);
    checkOutput("ovf.wrap_cnt2", 32'(wrap_cnt2), 3);
    checkOutput("ovf.evt_ovf",   32'(evt_ovf),   32'(OVF_EXP));
    applyStimulus(4'd15, 1'b0, 1'b0);
    checkOutput("ovf.sticky", 32'(evt_ovf), 32'(OVF_EXP));
    applyStimulus(4'd15, 1'b0, 1'b1);
    checkOutput("ovf.ack_valid", 32'(evt_valid), 0);
    checkOutput("ovf.cleared",   32'(evt_ovf),   0);

    // An acknowledge in the same cycle as a new down-wrap replaces the
    // pending up-event.
    applyStimulus(4'd0, 1'b0, 1'b0);
    checkOutput("ackwrap.setup_dir", 32'(evt_dir), 1);
    applyStimulus(4'd15, 1'b0, 1'b1);
    checkOutput("ackwrap.evt_valid", 32'(evt_valid), 1);
    checkOutput("ackwrap.evt_dir",   32'(evt_dir),   0);
    checkOutput("ackwrap.evt_ovf",   32'(evt_ovf),   0);
    checkOutput("ackwrap.wrap_cnt",  32'(wrap_cnt),  6);
    checkOutput("ackwrap.wrap_cnt2", 32'(wrap_cnt2), 3);

    // An acknowledge in IDLE has no effect; pulse the ack once so the
    // pending event clears, then again while idle.
    applyStimulus(4'd15, 1'b0, 1'b1);
    applyStimulus(4'd15, 1'b0, 1'b1);
    checkOutput("idle_ack.evt_valid", 32'(evt_valid), 0);

    // Reset asserted while an event is pending must clear every output
    // without waiting for a clock edge.
    applyStimulus(4'd0, 1'b0, 1'b0);
    checkOutput("midpend.evt_valid", 32'(evt_valid), 1);
    count = 4'd15;
    sel   = 1'b1;
    reset = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(posedge clk);
    #1;

    // Release with count held at 15, then step to 0. Then toggle sel while
    // count holds at 0.
    reset = 1'b1;
    applyStimulus(4'd15, 1'b1, 1'b0);
    checkOutput("rel.no_wrap", 32'(wrap_up), 0);
    applyStimulus(4'd0, 1'b1, 1'b0);
    checkOutput("rel.wrap_up",  32'(wrap_up),  1);
    checkOutput("rel.wrap_cnt", 32'(wrap_cnt), 1);
    applyStimulus(4'd0, 1'b0, 1'b0);
    checkOutput("rel.dir_change", 32'(dir_change), 1);
    checkOutput("rel.hold_up",    32'(wrap_up),    0);
    checkOutput("rel.hold_down",  32'(wrap_down),  0);
    applyStimulus(4'd0, 1'b0, 1'b0);
    checkOutput("rel.dir_once", 32'(dir_change), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
